// File: rtl/vga_pkg.sv
// Shared VGA timing constants, default arbiter sizing and common types.
package vga_pkg;

  // 640x480@60 timing (pixels / lines)
  localparam int unsigned HACTIVE = 640;
  localparam int unsigned HFP     = 16;
  localparam int unsigned HSYNC   = 96;
  localparam int unsigned HBP     = 48;
  localparam int unsigned HTOTAL  = HACTIVE + HFP + HSYNC + HBP;
  localparam int unsigned VACTIVE = 480;
  localparam int unsigned VFP     = 10;
  localparam int unsigned VSYNC   = 2;
  localparam int unsigned VBP     = 33;
  localparam int unsigned VTOTAL  = VACTIVE + VFP + VSYNC + VBP;

  // Default framebuffer sizing; 160x120 << 2 covers 640x480 exactly.
  localparam int unsigned DEF_DW          = 8;
  localparam int unsigned DEF_FB_W        = 160;
  localparam int unsigned DEF_FB_H        = 120;
  localparam int unsigned DEF_SCALE_SHIFT = 2;
  localparam int unsigned DEF_FIFO_DEPTH  = 8;
  localparam int unsigned DEF_AW          = $clog2(DEF_FB_W * DEF_FB_H);

  typedef logic [DEF_DW-1:0] pixel_t;

  // What the single RAM port does in a given cycle.
  typedef enum logic [1:0] {
    SlotIdle,
    SlotRead,
    SlotWrite,
    SlotClear
  } slot_e;

  // Framebuffer clear engine states.
  typedef enum logic [0:0] {
    StIdle,
    StClear
  } clear_st_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle for vga_fb_arbiter: timing inputs, pixel-write channel, RAM port
// and delayed display outputs. FB_CLEAR_EN adds the clear-engine signals.
interface vga_fb_arbiter_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 15
);
  // Timing generator side
  logic [9:0]    x;
  logic [9:0]    y;
  logic          hsync;
  logic          vsync;
  logic          blank_b;
  // Pixel-write requester
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  // Framebuffer RAM port
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // Display side
  logic [DW-1:0] pix_data;
  logic          hsync_d;
  logic          vsync_d;
  logic          blank_b_d;
`ifdef FB_CLEAR_EN
  logic          clear_req;
  logic          clear_busy;
  logic [DW-1:0] clear_color;

  modport master (
    output x, y, hsync, vsync, blank_b, wr_valid, wr_addr, wr_data, mem_rdata,
           clear_req, clear_color,
    input  wr_ready, mem_addr, mem_we, mem_wdata, pix_data, hsync_d, vsync_d, blank_b_d,
           clear_busy
  );

  modport slave (
    input  x, y, hsync, vsync, blank_b, wr_valid, wr_addr, wr_data, mem_rdata,
           clear_req, clear_color,
    output wr_ready, mem_addr, mem_we, mem_wdata, pix_data, hsync_d, vsync_d, blank_b_d,
           clear_busy
  );
`else
  modport master (
    output x, y, hsync, vsync, blank_b, wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata, pix_data, hsync_d, vsync_d, blank_b_d
  );

  modport slave (
    input  x, y, hsync, vsync, blank_b, wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata, pix_data, hsync_d, vsync_d, blank_b_d
  );
`endif
endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous write-request FIFO. Depth must be a power of two (>= 2) so the
// pointers wrap naturally. Pushes when full and pops when empty are ignored.
module fb_wr_fifo #(
  parameter int unsigned Width = 23,
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter between the VGA display fetch and a pixel-write
// requester. Display reads own every active-video cycle; queued writes drain
// in blanking. Sync/blank are delayed three cycles to line up with pix_data.
// Optional macro FB_CLEAR_EN adds a clear engine that fills the whole
// framebuffer with clear_color using free slots, ahead of the write FIFO.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned DW          = DEF_DW,
  parameter int unsigned FB_W        = DEF_FB_W,
  parameter int unsigned FB_H        = DEF_FB_H,
  parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input logic            clk,
  input logic            reset_n,
  vga_fb_arbiter_if.slave bus
);

  localparam int unsigned AW    = $clog2(FB_W * FB_H);
  localparam int unsigned FifoW = AW + DW;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FifoW-1:0] fifo_head;
  logic [CntW-1:0]  fifo_count;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;

  assign bus.wr_ready = (fifo_count != CntW'(FIFO_DEPTH));
  assign fifo_push    = bus.wr_valid & ~fifo_full;
  assign head_addr    = fifo_head[FifoW-1:DW];
  assign head_data    = fifo_head[DW-1:0];

  fb_wr_fifo #(
    .Width (FifoW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .wdata_i ({bus.wr_addr, bus.wr_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Display address: constant multiply in AW bits, exact for in-range x/y.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] disp_addr;
  assign disp_addr = AW'(bus.y >> SCALE_SHIFT) * AW'(FB_W) + AW'(bus.x >> SCALE_SHIFT);

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  logic          clear_active;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_color;

`ifdef FB_CLEAR_EN
  localparam int unsigned ClearLast = FB_W * FB_H - 1;

  clear_st_e     clr_st_q;
  logic [AW-1:0] clr_addr_q;
  logic          clr_busy_q;

  // Clear FSM: one address per free slot; requests while clearing are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_st_q   <= StIdle;
      clr_addr_q <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      unique case (clr_st_q)
        StIdle: begin
          if (bus.clear_req) begin
            clr_st_q   <= StClear;
            clr_addr_q <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        StClear: begin
          if (!bus.blank_b) begin
            if (clr_addr_q == AW'(ClearLast)) begin
              clr_st_q   <= StIdle;
              clr_busy_q <= 1'b0;
            end else begin
              clr_addr_q <= clr_addr_q + 1'b1;
            end
          end
        end
        default: begin
          clr_st_q   <= StIdle;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.clear_busy = clr_busy_q;
  assign clear_active   = (clr_st_q == StClear);
  assign clr_addr       = clr_addr_q;
  assign clr_color      = bus.clear_color;
`else
  assign clear_active = 1'b0;
  assign clr_addr     = '0;
  assign clr_color    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Slot select: display first, then clear, then FIFO.
  // ---------------------------------------------------------------------------
  slot_e slot;

  // Pick the owner of this cycle's RAM access.
  always_comb begin
    slot = SlotIdle;
    if (bus.blank_b)      slot = SlotRead;
    else if (clear_active) slot = SlotClear;
    else if (!fifo_empty)  slot = SlotWrite;
  end

  assign fifo_pop = (slot == SlotWrite);

  // ---------------------------------------------------------------------------
  // Registered RAM port
  // ---------------------------------------------------------------------------
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;

  // RAM command for the selected slot; address/data hold when idle.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    unique case (slot)
      SlotRead: mem_addr_d = disp_addr;
      SlotWrite: begin
        mem_addr_d  = head_addr;
        mem_wdata_d = head_data;
        mem_we_d    = 1'b1;
      end
      SlotClear: begin
        mem_addr_d  = clr_addr;
        mem_wdata_d = clr_color;
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // RAM port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;

  // ---------------------------------------------------------------------------
  // Sync delay line and pixel output
  // Stage [0] is t+1, [1] is t+2 (read data arrives), [2] is t+3 (output).
  // ---------------------------------------------------------------------------
  logic [2:0]    hs_pipe_q, vs_pipe_q, bl_pipe_q;
  logic [DW-1:0] pix_q, pix_d;

  assign pix_d = bl_pipe_q[1] ? bus.mem_rdata : '0;

  // Delay syncs three cycles and register the blank-qualified pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe_q <= 3'b111;
      vs_pipe_q <= 3'b111;
      bl_pipe_q <= 3'b000;
      pix_q     <= '0;
    end else begin
      hs_pipe_q <= {hs_pipe_q[1:0], bus.hsync};
      vs_pipe_q <= {vs_pipe_q[1:0], bus.vsync};
      bl_pipe_q <= {bl_pipe_q[1:0], bus.blank_b};
      pix_q     <= pix_d;
    end
  end

  assign bus.pix_data  = pix_q;
  assign bus.hsync_d   = hs_pipe_q[2];
  assign bus.vsync_d   = vs_pipe_q[2];
  assign bus.blank_b_d = bl_pipe_q[2];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: table vectors, hand sequences and random traffic,
// all scored against a transaction-level model of the framebuffer.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int FBW   = 160;
  localparam int FBH   = 120;
  localparam int NPIX  = FBW * FBH;
  localparam int DEPTH = 8;
  localparam int AW    = 15;
  localparam int DW    = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  vga_fb_arbiter #(
    .DW          (DW),
    .FB_W        (FBW),
    .FB_H        (FBH),
    .SCALE_SHIFT (2),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous single-port RAM (environment, not the reference).
  pixel_t ram [NPIX];
  always @(posedge clk) begin
    if (int'(bus.mem_addr) < NPIX) begin
      bus.mem_rdata <= ram[bus.mem_addr];
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct packed { logic [AW-1:0] addr; pixel_t data; } wr_t;
  typedef struct packed { pixel_t pix; logic hs; logic vs; logic bl; } out_t;
  localparam out_t RstOut = '{pix: 8'h00, hs: 1'b1, vs: 1'b1, bl: 1'b0};

  wr_t           pend[$];
  pixel_t        fbm [NPIX];
  out_t          hist[$];
  logic [AW-1:0] last_addr;
  pixel_t        last_wdata;
  bit            last_acc;
  bit            collect;
  int            obs[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
`ifdef FB_CLEAR_EN
  bit            clr_act;
  int            clr_cnt;
`endif

  function automatic pixel_t pat(int a);
    return (a == 321) ? 8'hA5 : 8'(a * 7 + 3);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(int x, int y, bit bl);
    bus.x       = 10'(x);
    bus.y       = 10'(y);
    bus.blank_b = bl;
    bus.hsync   = 1'b1;
    bus.vsync   = 1'b1;
  endtask

  // One clock: predict from current inputs, advance, compare everything.
  task automatic cycle();
    wr_t           item;
    out_t          o;
    bit            we_e;
    logic [AW-1:0] a_e;
    pixel_t        d_e;
    int            idx;
    bit            acc;
`ifdef FB_CLEAR_EN
    bit            clr_pre;
    clr_pre = clr_act;
`endif
    chk("wr_ready_pre", bus.wr_ready, pend.size() < DEPTH);
    acc  = bus.wr_valid && (pend.size() < DEPTH);
    we_e = 1'b0;
    a_e  = last_addr;
    d_e  = last_wdata;
    o    = '{pix: 8'h00, hs: bus.hsync, vs: bus.vsync, bl: bus.blank_b};
    if (bus.blank_b) begin
      idx   = (int'(bus.y) / 4) * FBW + int'(bus.x) / 4;
      a_e   = idx[AW-1:0];
      o.pix = fbm[idx];
    end
`ifdef FB_CLEAR_EN
    else if (clr_pre) begin
      we_e      = 1'b1;
      a_e       = clr_cnt[AW-1:0];
      d_e       = bus.clear_color;
      fbm[clr_cnt] = bus.clear_color;
      if (clr_cnt == NPIX - 1) clr_act = 1'b0;
      else clr_cnt++;
    end
`endif
    else if (pend.size() > 0) begin
      item = pend.pop_front();
      we_e = 1'b1;
      a_e  = item.addr;
      d_e  = item.data;
      fbm[item.addr] = item.data;
    end
`ifdef FB_CLEAR_EN
    if (bus.clear_req && !clr_pre) begin
      clr_act = 1'b1;
      clr_cnt = 0;
    end
`endif
    if (acc) pend.push_back('{addr: bus.wr_addr, data: bus.wr_data});
    last_addr  = a_e;
    last_wdata = d_e;
    last_acc   = acc;
    hist.push_back(o);
    @(posedge clk);
    #1;
    chk("mem_we", bus.mem_we, we_e);
    chk("mem_addr", bus.mem_addr, a_e);
    chk("mem_wdata", bus.mem_wdata, d_e);
    chk("wr_ready", bus.wr_ready, pend.size() < DEPTH);
    chk("pix_data", bus.pix_data, hist[0].pix);
    chk("hsync_d", bus.hsync_d, hist[0].hs);
    chk("vsync_d", bus.vsync_d, hist[0].vs);
    chk("blank_b_d", bus.blank_b_d, hist[0].bl);
`ifdef FB_CLEAR_EN
    chk("clear_busy", bus.clear_busy, clr_act);
`endif
    void'(hist.pop_front());
    if (collect && bus.mem_we) obs.push_back(int'(bus.mem_addr));
  endtask

  task automatic do_reset();
    bus.wr_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_pix_data", bus.pix_data, 0);
    chk("rst_hsync_d", bus.hsync_d, 1);
    chk("rst_vsync_d", bus.vsync_d, 1);
    chk("rst_blank_b_d", bus.blank_b_d, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    pend.delete();
    hist.delete();
    hist.push_back(RstOut);
    hist.push_back(RstOut);
    last_addr  = '0;
    last_wdata = '0;
`ifdef FB_CLEAR_EN
    clr_act = 1'b0;
    clr_cnt = 0;
`endif
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic push_blocking(int a, int d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(a);
    bus.wr_data  = 8'(d);
    cycle();
    bus.wr_valid = 1'b0;
  endtask

  typedef struct {
    int x;
    int y;
    int exp_addr;
    int exp_pix;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      ram[i] = pat(i);
      fbm[i] = pat(i);
    end
    set_in(0, 0, 1'b0);
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    collect       = 1'b0;
`ifdef FB_CLEAR_EN
    bus.clear_req   = 1'b0;
    bus.clear_color = 8'h00;
`endif
    #2;
    do_reset();

    // Address/pixel table; exp_addr = (y>>2)*160 + (x>>2).
    vecs[0] = '{x: 5,   y: 9,   exp_addr: 321,   exp_pix: 'hA5};
    vecs[1] = '{x: 0,   y: 0,   exp_addr: 0,     exp_pix: 0};
    vecs[2] = '{x: 639, y: 479, exp_addr: 19199, exp_pix: 0};
    vecs[3] = '{x: 3,   y: 3,   exp_addr: 0,     exp_pix: 0};
    vecs[4] = '{x: 4,   y: 4,   exp_addr: 161,   exp_pix: 0};
    vecs[5] = '{x: 639, y: 0,   exp_addr: 159,   exp_pix: 0};
    vecs[6] = '{x: 0,   y: 479, exp_addr: 19040, exp_pix: 0};
    vecs[7] = '{x: 320, y: 240, exp_addr: 9680,  exp_pix: 0};
    for (int i = 1; i < 8; i++) vecs[i].exp_pix = int'(pat(vecs[i].exp_addr));

    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].x, vecs[i].y, 1'b1);
      cycle();
      chk("tbl_addr", bus.mem_addr, vecs[i].exp_addr);
      chk("tbl_we", bus.mem_we, 0);
      set_in(0, 0, 1'b0);
      cycle();
      cycle();
      chk("tbl_pix", bus.pix_data, vecs[i].exp_pix);
      chk("tbl_blank_d", bus.blank_b_d, 1);
    end

    // Single write waits for blanking.
    set_in(8, 8, 1'b1);
    push_blocking(100, 'h3C);
    cycle();
    chk("wr_wait_we", bus.mem_we, 0);
    cycle();
    chk("wr_wait_we2", bus.mem_we, 0);
    set_in(0, 0, 1'b0);
    cycle();
    chk("wr_land_we", bus.mem_we, 1);
    chk("wr_land_addr", bus.mem_addr, 100);
    chk("wr_land_data", bus.mem_wdata, 'h3C);
    cycle();

    // Fill FIFO, then drain in order.
    set_in(12, 20, 1'b1);
    for (int i = 0; i < 8; i++) push_blocking(200 + i, 'h10 + i);
    chk("full_ready", bus.wr_ready, 0);
    set_in(0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 0) chk("ready_after_pop", bus.wr_ready, 1);
      chk("drain_addr", bus.mem_addr, 200 + i);
      chk("drain_data", bus.mem_wdata, 'h10 + i);
    end
    cycle();
    chk("drain_done_we", bus.mem_we, 0);

    // Full FIFO with held wr_valid during blanking: nothing lost or reordered.
    set_in(40, 40, 1'b1);
    for (int i = 0; i < 8; i++) push_blocking(300 + i, 'h40 + i);
    set_in(0, 0, 1'b0);
    obs.delete();
    collect = 1'b1;
    begin
      int k = 0;
      for (int guard = 0; guard < 100 && k < 6; guard++) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(308 + k);
        bus.wr_data  = 8'(8'h48 + k);
        cycle();
        if (last_acc) k++;
      end
      chk("hold_accepted", k, 6);
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 12; i++) cycle();
    collect = 1'b0;
    chk("hold_count", obs.size(), 14);
    for (int i = 0; i < obs.size() && i < 14; i++) chk("hold_order", obs[i], 300 + i);

    // Reset mid-frame with queued writes drops them.
    set_in(100, 100, 1'b1);
    for (int i = 0; i < 3; i++) push_blocking(500 + i, 'h77);
    do_reset();
    chk("post_rst_ready", bus.wr_ready, 1);
    set_in(0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_we", bus.mem_we, 0);
    end

    // Random traffic with bursts of active video and blanking.
    begin
      bit bl = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 15) == 0) bl = ~bl;
        set_in($urandom_range(0, 639), $urandom_range(0, 479), bl);
        bus.hsync = 1'($urandom_range(0, 1));
        bus.vsync = 1'($urandom_range(0, 1));
        if (!bus.wr_valid || last_acc) begin
          bus.wr_valid = 1'($urandom_range(0, 1));
          bus.wr_addr  = AW'($urandom_range(0, NPIX - 1));
          bus.wr_data  = 8'($urandom);
        end
        cycle();
      end
      bus.wr_valid = 1'b0;
      set_in(0, 0, 1'b0);
      for (int i = 0; i < 12; i++) cycle();
    end

`ifdef FB_CLEAR_EN
    // Clear ahead of a queued write.
    set_in(0, 0, 1'b1);
    push_blocking(77, 'h5A);
    bus.clear_color = 8'h00;
    bus.clear_req   = 1'b1;
    cycle();
    bus.clear_req = 1'b0;
    chk("clr_busy_start", bus.clear_busy, 1);
    set_in(0, 0, 1'b0);
    begin
      int n = 0;
      while (bus.clear_busy && n < NPIX + 50) begin
        cycle();
        n++;
      end
      chk("clr_cycles", n, NPIX);
    end
    cycle();
    chk("clr_then_wr_addr", bus.mem_addr, 77);
    chk("clr_then_wr_data", bus.mem_wdata, 'h5A);
    chk("clr_then_wr_we", bus.mem_we, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
